// File: rtl/pio_pkg.sv
// Shared types and helpers for the PIO output shift register engine.
// Provides the engine FSM state type, shift-direction encodings and the
// count decode used for both OUT bit counts and the pull threshold.
package pio_pkg;

   // Engine FSM states; WAIT_FILL and EXEC are only reachable with autopull built in
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_PULL = 2'd1,
      ST_WAIT_FILL = 2'd2,
      ST_EXEC      = 2'd3
   } osr_state_e;

   // Shift direction encoding as seen on the shiftdir input
   localparam logic SHIFT_LEFT  = 1'b0;
   localparam logic SHIFT_RIGHT = 1'b1;

   // A zero count field means a full word
   function automatic int unsigned decode_count(input int unsigned field,
                                                input int unsigned full);
      return (field == 0) ? full : field;
   endfunction

endpackage

// File: rtl/pio_osr_shifter.sv
// Combinational OSR shifter. Given the OSR, a bit count n (1..DATA_W) and a
// direction, returns the right-aligned shifted-out bits and the next OSR value
// with zeros shifted in. A double-width datapath makes n = DATA_W a plain shift
// (out_data = osr, osr_next = 0) without a shift-by-width corner case.
module pio_osr_shifter
   import pio_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic [DATA_W-1:0] osr,
   input  logic [CNT_W-1:0]  n,
   input  logic              dir,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] osr_next
);

   logic [2*DATA_W-1:0] wide_right;
   logic [2*DATA_W-1:0] wide_left;
   logic [CNT_W-1:0]    back_shift;

   // Right shift: consumed bits land at the top of the low half.
   assign wide_right = {osr, {DATA_W{1'b0}}} >> n;
   // Left shift: consumed bits land at the bottom of the high half.
   assign wide_left  = {{DATA_W{1'b0}}, osr} << n;
   // Distance needed to right-align the bits consumed by a right shift.
   assign back_shift = CNT_W'(DATA_W) - n;

   // Select the direction and right-align the consumed bits
   always_comb begin
      if (dir == SHIFT_RIGHT) begin
         out_data = wide_right[DATA_W-1:0] >> back_shift;
         osr_next = wide_right[2*DATA_W-1:DATA_W];
      end else begin
         out_data = wide_left[2*DATA_W-1:DATA_W];
         osr_next = wide_left[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/pio_osr_engine.sv
// PIO output shift register engine: holds the OSR and its shift counter,
// executes MOV-to-OSR, PULL and OUT requests from the instruction decoder,
// pops the TX FIFO for pulls and autopull refills, and raises stall while a
// request waits for FIFO data.
// Optional feature: define PIO_OSR_AUTOPULL_EN to build the autopull refill
// path (WAIT_FILL/EXEC). Without it autopull_en is ignored and OUT never stalls.
module pio_osr_engine
   import pio_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              fifo_valid,
   output logic              fifo_ready,
   input  logic              mov_load,
   input  logic [DATA_W-1:0] mov_data,
   input  logic              pull_req,
   input  logic              pull_block,
   input  logic              pull_ifempty,
   input  logic [DATA_W-1:0] x_in,
   input  logic              out_req,
   input  logic [CNT_W-1:0]  out_count,
   input  logic              shiftdir,
   input  logic              autopull_en,
   input  logic [CNT_W-1:0]  pull_thresh,
   output logic [DATA_W-1:0] out_data,
   output logic              out_done,
   output logic              stall,
   output logic [DATA_W-1:0] osr,
   output logic [CNT_W-1:0]  shift_cnt
);

   osr_state_e        state;
   logic [CNT_W-1:0]  req_n;
   logic [CNT_W-1:0]  thr;
   logic [CNT_W-1:0]  shift_n;
   logic              shift_dir;
   logic [DATA_W-1:0] sh_out;
   logic [DATA_W-1:0] sh_osr;
   logic [CNT_W:0]    cnt_sum;
   logic [CNT_W-1:0]  cnt_next;
   logic              pull_skip;
   logic              refill;

   // Decoded OUT bit count and threshold (zero field means a full word).
   assign req_n = CNT_W'(decode_count(32'(out_count), DATA_W));
   assign thr   = CNT_W'(decode_count(32'(pull_thresh), DATA_W));

   // PULL IFEMPTY is a no-op while the OSR still holds enough unshifted bits.
   assign pull_skip = pull_ifempty && (shift_cnt < thr);

`ifdef PIO_OSR_AUTOPULL_EN
   logic [CNT_W-1:0] lat_n;
   logic             lat_dir;

   // An OUT on an exhausted OSR refills from the FIFO before shifting.
   assign refill    = autopull_en && (shift_cnt >= thr);
   // EXEC replays the OUT captured at accept time; IDLE shifts the live request.
   assign shift_n   = (state == ST_EXEC) ? lat_n   : req_n;
   assign shift_dir = (state == ST_EXEC) ? lat_dir : shiftdir;
`else
   logic unused_autopull;

   // Without the refill path an empty OSR simply shifts out zeros.
   assign unused_autopull = autopull_en;
   assign refill          = 1'b0;
   assign shift_n         = req_n;
   assign shift_dir       = shiftdir;
`endif

   // Saturating counter update computed one bit wider to avoid wrap.
   assign cnt_sum  = {1'b0, shift_cnt} + {1'b0, shift_n};
   assign cnt_next = (cnt_sum > (CNT_W + 1)'(DATA_W)) ? CNT_W'(DATA_W)
                                                      : cnt_sum[CNT_W-1:0];

   pio_osr_shifter #(
      .DATA_W   (DATA_W)
   ) u_shifter (
      .osr      (osr),
      .n        (shift_n),
      .dir      (shift_dir),
      .out_data (sh_out),
      .osr_next (sh_osr)
   );

   // Pop strobe: high only in a cycle that actually consumes the FIFO head
   always_comb begin
      // NOTE: default first so every path assigns fifo_ready and no latch is inferred.
      fifo_ready = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE:      fifo_ready = fifo_valid && pull_req && !mov_load && !pull_skip;
            ST_WAIT_PULL: fifo_ready = fifo_valid;
`ifdef PIO_OSR_AUTOPULL_EN
            ST_WAIT_FILL: fifo_ready = fifo_valid;
`endif
            default:      fifo_ready = 1'b0;
         endcase
      end
   end

   // Request FSM, OSR, shift counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: async reset clears every register, so an in-flight request is dropped at once.
         state     <= ST_IDLE;
         osr       <= '0;
         shift_cnt <= CNT_W'(DATA_W);
         out_data  <= '0;
         out_done  <= 1'b0;
         stall     <= 1'b0;
`ifdef PIO_OSR_AUTOPULL_EN
         lat_n     <= '0;
         lat_dir   <= SHIFT_LEFT;
`endif
      end else begin
         // NOTE: non-blocking assignments keep all state updates on the same clock edge.
         out_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mov_load) begin
                  osr       <= mov_data;
                  shift_cnt <= '0;
               end else if (pull_req) begin
                  if (pull_skip) begin
                     // Enough data left in the OSR: complete without loading.
                  end else if (fifo_valid) begin
                     osr       <= fifo_data;
                     shift_cnt <= '0;
                  end else if (!pull_block) begin
                     osr       <= x_in;
                     shift_cnt <= '0;
                  end else begin
                     state <= ST_WAIT_PULL;
                     stall <= 1'b1;
                  end
               end else if (out_req) begin
                  if (refill) begin
`ifdef PIO_OSR_AUTOPULL_EN
                     lat_n   <= req_n;
                     lat_dir <= shiftdir;
                     state   <= ST_WAIT_FILL;
                     stall   <= 1'b1;
`endif
                  end else begin
                     out_data  <= sh_out;
                     osr       <= sh_osr;
                     shift_cnt <= cnt_next;
                     out_done  <= 1'b1;
                  end
               end
            end
            ST_WAIT_PULL: begin
               if (fifo_valid) begin
                  osr       <= fifo_data;
                  shift_cnt <= '0;
                  state     <= ST_IDLE;
                  stall     <= 1'b0;
               end
            end
`ifdef PIO_OSR_AUTOPULL_EN
            ST_WAIT_FILL: begin
               if (fifo_valid) begin
                  osr       <= fifo_data;
                  shift_cnt <= '0;
                  state     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               out_data  <= sh_out;
               osr       <= sh_osr;
               shift_cnt <= cnt_next;
               out_done  <= 1'b1;
               state     <= ST_IDLE;
               stall     <= 1'b0;
            end
`endif
            default: begin
               state <= ST_IDLE;
               stall <= 1'b0;
            end
         endcase
      end
   end

   // Flag overlapping requests in IDLE; only the highest-priority one is honoured
   always @(posedge clk) begin
      if (!rst && state == ST_IDLE) begin
         assert ($onehot0({mov_load, pull_req, out_req}))
            else $warning("pio_osr_engine: overlapping requests, lower priority dropped");
      end
   end

endmodule

// File: tb/tb_pio_osr_engine.sv
// Self-checking bench for pio_osr_engine (DATA_W = 32). Directed scenarios plus
// a randomized back-to-back sequence, all checked against a word-level model of
// the OSR (value, bits consumed, last shifted-out word). Expectations for the
// autopull scenario follow whether PIO_OSR_AUTOPULL_EN is defined.
module tb_pio_osr_engine;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_valid;
   logic              fifo_ready;
   logic              mov_load;
   logic [DATA_W-1:0] mov_data;
   logic              pull_req;
   logic              pull_block;
   logic              pull_ifempty;
   logic [DATA_W-1:0] x_in;
   logic              out_req;
   logic [CNT_W-1:0]  out_count;
   logic              shiftdir;
   logic              autopull_en;
   logic [CNT_W-1:0]  pull_thresh;
   logic [DATA_W-1:0] out_data;
   logic              out_done;
   logic              stall;
   logic [DATA_W-1:0] osr;
   logic [CNT_W-1:0]  shift_cnt;

   int total = 0;
   int bad   = 0;
   int pops  = 0;

   // Reference model state
   logic [31:0] m_osr;
   int          m_cnt;
   logic [31:0] m_out;

   pio_osr_engine #(.DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_data    (fifo_data),
      .fifo_valid   (fifo_valid),
      .fifo_ready   (fifo_ready),
      .mov_load     (mov_load),
      .mov_data     (mov_data),
      .pull_req     (pull_req),
      .pull_block   (pull_block),
      .pull_ifempty (pull_ifempty),
      .x_in         (x_in),
      .out_req      (out_req),
      .out_count    (out_count),
      .shiftdir     (shiftdir),
      .autopull_en  (autopull_en),
      .pull_thresh  (pull_thresh),
      .out_data     (out_data),
      .out_done     (out_done),
      .stall        (stall),
      .osr          (osr),
      .shift_cnt    (shift_cnt)
   );

   always #5 clk = ~clk;

   // Count FIFO transfers mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (!rst && fifo_valid && fifo_ready) pops++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      mov_load = 1'b0;
      pull_req = 1'b0;
      out_req  = 1'b0;
   endtask

   task automatic model_load(input logic [31:0] v);
      m_osr = v;
      m_cnt = 0;
   endtask

   // Word-level OUT: take n bits from the chosen end, shift zeros in
   task automatic model_shift(input int field, input bit dir);
      int n;
      longint unsigned w;
      n = (field == 0) ? 32 : field;
      w = 64'(m_osr);
      if (dir) begin
         m_out = 32'(w & ((64'd1 << n) - 64'd1));
         m_osr = 32'(w >> n);
      end else begin
         m_out = 32'(w >> (32 - n));
         m_osr = 32'(w << n);
      end
      m_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
   endtask

   task automatic drive_out(input int field, input bit dir);
      out_count = CNT_W'(field);
      shiftdir  = dir;
      out_req   = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fifo_data = '0; fifo_valid = 1'b0; mov_data = '0; x_in = '0;
      pull_block = 1'b0; pull_ifempty = 1'b0; out_count = '0; shiftdir = 1'b0;
      autopull_en = 1'b0; pull_thresh = '0;
      clear_reqs();
      #12;
      if (osr !== 32'h0) begin bad++; $display("FAIL reset_osr got=%h want=0", osr); end total++;
      if (shift_cnt !== 6'd32) begin bad++; $display("FAIL reset_cnt got=%0d want=32", shift_cnt); end total++;
      if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=0", out_data); end total++;
      if (out_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", out_done); end total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end total++;
      @(negedge clk);
      rst = 1'b0;
      step();
      m_osr = '0; m_cnt = 32; m_out = '0;
   endtask

   task automatic test_blocking_pull();
      int p0;
      p0 = pops;
      pull_block = 1'b1; fifo_valid = 1'b1; fifo_data = 32'hDEADBEEF; pull_req = 1'b1;
      #1;
      if (fifo_ready !== 1'b1) begin bad++; $display("FAIL pull_ready got=%b want=1", fifo_ready); end total++;
      step();
      clear_reqs(); fifo_valid = 1'b0;
      model_load(32'hDEADBEEF);
      if (osr !== m_osr) begin bad++; $display("FAIL pull_osr got=%h want=%h", osr, m_osr); end total++;
      if (shift_cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL pull_cnt got=%0d want=%0d", shift_cnt, m_cnt); end total++;
      if (pops - p0 !== 1) begin bad++; $display("FAIL pull_pops got=%0d want=1", pops - p0); end total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL pull_stall got=%b want=0", stall); end total++;
   endtask

   task automatic test_out_shifts();
      drive_out(8, 1'b1);
      step(); clear_reqs(); model_shift(8, 1'b1);
      if (out_data !== 32'hEF || out_data !== m_out) begin bad++; $display("FAIL outr_data got=%h want=%h", out_data, m_out); end total++;
      if (osr !== 32'h00DEADBE) begin bad++; $display("FAIL outr_osr got=%h want=00deadbe", osr); end total++;
      if (shift_cnt !== 6'd8) begin bad++; $display("FAIL outr_cnt got=%0d want=8", shift_cnt); end total++;
      if (out_done !== 1'b1) begin bad++; $display("FAIL outr_done got=%b want=1", out_done); end total++;
      drive_out(4, 1'b0);
      step(); clear_reqs(); model_shift(4, 1'b0);
      if (out_data !== m_out) begin bad++; $display("FAIL outl_data got=%h want=%h", out_data, m_out); end total++;
      if (osr !== 32'h0DEADBE0) begin bad++; $display("FAIL outl_osr got=%h want=0deadbe0", osr); end total++;
      if (shift_cnt !== 6'd12) begin bad++; $display("FAIL outl_cnt got=%0d want=12", shift_cnt); end total++;
      step();
      if (out_done !== 1'b0 || out_data !== m_out) begin bad++; $display("FAIL out_hold done=%b data=%h want done=0 data=%h", out_done, out_data, m_out); end total++;
   endtask

   task automatic test_full_word();
      mov_data = 32'hCAFEF00D; mov_load = 1'b1;
      step(); clear_reqs(); model_load(32'hCAFEF00D);
      if (osr !== m_osr || shift_cnt !== 6'd0) begin bad++; $display("FAIL mov osr=%h cnt=%0d want %h 0", osr, shift_cnt, m_osr); end total++;
      drive_out(0, 1'b0);
      step(); clear_reqs(); model_shift(0, 1'b0);
      if (out_data !== 32'hCAFEF00D) begin bad++; $display("FAIL full_data got=%h want=cafef00d", out_data); end total++;
      if (osr !== 32'h0 || shift_cnt !== 6'd32) begin bad++; $display("FAIL full_state osr=%h cnt=%0d want 0 32", osr, shift_cnt); end total++;
      drive_out(8, 1'b1);
      step(); clear_reqs(); model_shift(8, 1'b1);
      if (out_data !== 32'h0 || out_done !== 1'b1) begin bad++; $display("FAIL empty_out data=%h done=%b want 0 1", out_data, out_done); end total++;
      if (shift_cnt !== 6'd32) begin bad++; $display("FAIL empty_cnt got=%0d want=32", shift_cnt); end total++;
   endtask

   task automatic test_autopull();
      int p0;
      p0 = pops;
      autopull_en = 1'b1; pull_thresh = 6'd32; fifo_valid = 1'b0;
      drive_out(8, 1'b1);
      step(); clear_reqs();
`ifdef PIO_OSR_AUTOPULL_EN
      for (int i = 0; i < 3; i++) begin
         if (stall !== 1'b1 || fifo_ready !== 1'b0) begin bad++; $display("FAIL ap_wait%0d stall=%b ready=%b want 1 0", i, stall, fifo_ready); end total++;
         if (i < 2) step();
      end
      fifo_data = 32'h12345678; fifo_valid = 1'b1;
      #1;
      if (fifo_ready !== 1'b1) begin bad++; $display("FAIL ap_ready got=%b want=1", fifo_ready); end total++;
      step(); fifo_valid = 1'b0;
      if (stall !== 1'b1 || out_done !== 1'b0) begin bad++; $display("FAIL ap_exec stall=%b done=%b want 1 0", stall, out_done); end total++;
      step();
      model_load(32'h12345678); model_shift(8, 1'b1);
      if (stall !== 1'b0 || out_done !== 1'b1) begin bad++; $display("FAIL ap_end stall=%b done=%b want 0 1", stall, out_done); end total++;
      if (out_data !== 32'h78 || out_data !== m_out) begin bad++; $display("FAIL ap_data got=%h want=%h", out_data, m_out); end total++;
      if (osr !== 32'h00123456 || shift_cnt !== 6'd8) begin bad++; $display("FAIL ap_state osr=%h cnt=%0d want 00123456 8", osr, shift_cnt); end total++;
      if (pops - p0 !== 1) begin bad++; $display("FAIL ap_pops got=%0d want=1", pops - p0); end total++;
`else
      model_shift(8, 1'b1);
      if (stall !== 1'b0 || out_done !== 1'b1) begin bad++; $display("FAIL ap_off stall=%b done=%b want 0 1", stall, out_done); end total++;
      if (out_data !== 32'h0 || shift_cnt !== 6'd32) begin bad++; $display("FAIL ap_off_out data=%h cnt=%0d want 0 32", out_data, shift_cnt); end total++;
      fifo_data = 32'h12345678; fifo_valid = 1'b1;
      step(); step();
      fifo_valid = 1'b0;
      if (pops - p0 !== 0 || osr !== m_osr) begin bad++; $display("FAIL ap_off_pops pops=%0d osr=%h want 0 %h", pops - p0, osr, m_osr); end total++;
`endif
      autopull_en = 1'b0; pull_thresh = '0;
   endtask

   task automatic test_nonblocking_pull();
      int p0;
      p0 = pops;
      fifo_valid = 1'b0; pull_block = 1'b0; pull_ifempty = 1'b0; x_in = 32'hA5A5A5A5; pull_req = 1'b1;
      #1;
      if (fifo_ready !== 1'b0) begin bad++; $display("FAIL nb_ready got=%b want=0", fifo_ready); end total++;
      step(); clear_reqs(); model_load(32'hA5A5A5A5);
      if (osr !== m_osr || shift_cnt !== 6'd0 || stall !== 1'b0) begin bad++; $display("FAIL nb_load osr=%h cnt=%0d stall=%b want %h 0 0", osr, shift_cnt, stall, m_osr); end total++;
      drive_out(8, 1'b1);
      step(); clear_reqs(); model_shift(8, 1'b1);
      pull_ifempty = 1'b1; pull_thresh = 6'd16; fifo_valid = 1'b1; fifo_data = 32'h11111111; pull_req = 1'b1;
      #1;
      if (fifo_ready !== 1'b0) begin bad++; $display("FAIL ife_ready got=%b want=0", fifo_ready); end total++;
      step(); clear_reqs(); fifo_valid = 1'b0;
      if (osr !== m_osr || shift_cnt !== 6'd8) begin bad++; $display("FAIL ife_state osr=%h cnt=%0d want %h 8", osr, shift_cnt, m_osr); end total++;
      if (pops - p0 !== 0) begin bad++; $display("FAIL nb_pops got=%0d want=0", pops - p0); end total++;
      pull_ifempty = 1'b0; pull_thresh = '0;
   endtask

   task automatic test_reset_mid_wait();
      mov_data = 32'h5A5A0001; mov_load = 1'b1;
      step(); clear_reqs();
      pull_block = 1'b1; fifo_valid = 1'b0; pull_req = 1'b1;
      step(); clear_reqs();
      if (stall !== 1'b1) begin bad++; $display("FAIL wp_stall got=%b want=1", stall); end total++;
      step();
      fifo_valid = 1'b1; fifo_data = 32'h77777777;
      #1;
      if (fifo_ready !== 1'b1) begin bad++; $display("FAIL wp_ready got=%b want=1", fifo_ready); end total++;
      rst = 1'b1;
      #1;
      if (stall !== 1'b0 || fifo_ready !== 1'b0) begin bad++; $display("FAIL rst_async stall=%b ready=%b want 0 0", stall, fifo_ready); end total++;
      if (osr !== 32'h0 || shift_cnt !== 6'd32 || out_done !== 1'b0) begin bad++; $display("FAIL rst_state osr=%h cnt=%0d done=%b want 0 32 0", osr, shift_cnt, out_done); end total++;
      fifo_valid = 1'b0; pull_block = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step();
      m_osr = '0; m_cnt = 32;
   endtask

   task automatic test_random_ops();
      int op, p0, exp_pops, thr_n, field;
      bit dir, fv, ife;
      for (int i = 0; i < 80; i++) begin
         op = $urandom_range(0, 2);
         p0 = pops;
         exp_pops = 0;
         case (op)
            0: begin
               mov_data = $urandom; mov_load = 1'b1;
               step(); clear_reqs(); model_load(mov_data);
            end
            1: begin
               ife = 1'($urandom_range(0, 1)); fv = 1'($urandom_range(0, 1));
               thr_n = $urandom_range(0, 32);
               pull_ifempty = ife; pull_thresh = CNT_W'(thr_n); fifo_valid = fv;
               pull_block = fv ? 1'($urandom_range(0, 1)) : 1'b0;
               fifo_data = $urandom; x_in = $urandom; pull_req = 1'b1;
               if (thr_n == 0) thr_n = 32;
               step(); clear_reqs(); fifo_valid = 1'b0;
               if (!(ife && m_cnt < thr_n)) begin
                  if (fv) begin model_load(fifo_data); exp_pops = 1; end
                  else model_load(x_in);
               end
            end
            default: begin
               field = $urandom_range(0, 32); dir = 1'($urandom_range(0, 1));
               drive_out(field, dir);
               step(); clear_reqs(); model_shift(field, dir);
               if (out_data !== m_out || out_done !== 1'b1) begin bad++; $display("FAIL rnd%0d_out data=%h done=%b want %h 1", i, out_data, out_done, m_out); end total++;
            end
         endcase
         if (osr !== m_osr || shift_cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL rnd%0d_state op=%0d osr=%h cnt=%0d want %h %0d", i, op, osr, shift_cnt, m_osr, m_cnt); end total++;
         if (pops - p0 !== exp_pops || stall !== 1'b0) begin bad++; $display("FAIL rnd%0d_pop pops=%0d stall=%b want %0d 0", i, pops - p0, stall, exp_pops); end total++;
      end
      pull_ifempty = 1'b0; pull_thresh = '0; pull_block = 1'b0;
   endtask

   initial begin
      test_reset();
      test_blocking_pull();
      test_out_shifts();
      test_full_word();
      test_autopull();
      test_nonblocking_pull();
      test_reset_mid_wait();
      test_random_ops();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
